// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and opcode constants for the PLC program-counter
//               sequencer (FSM state encoding, jump-class and call/return
//               opcodes, unconditional jump condition index).
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_OP    = 3'd1,
        S_TLO   = 3'd2,
        S_THI   = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } pc_state_t;

    localparam logic [3:0] JMP_CLASS   = 4'hF;
    localparam logic [7:0] OPC_CALL    = 8'hFB;
    localparam logic [7:0] OPC_RET     = 8'hFC;
    localparam logic [3:0] COND_ALWAYS = 4'hA;

    // Any opcode whose high nibble is JMP_CLASS carries two target bytes
    // (except RET when the return stack is built in).
    function automatic logic is_jump(input logic [7:0] opc);
        return (opc[7:4] == JMP_CLASS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_call_stack
// Description : Small LIFO of return addresses for CALL/RET.
//               Ports: clk, rst (async, active high), i_push, i_pop,
//               i_data (address to push), o_top (most recent entry),
//               o_full, o_empty. The caller never pushes when full or pops
//               when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_call_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_cnt_w-1:0] r_count;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_top_idx;

    assign w_wr_idx  = c_idx_w'(r_count);
    assign w_top_idx = c_idx_w'(r_count - c_cnt_w'(1));
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + c_cnt_w'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    // Entry storage needs no reset: only slots below r_count are ever read.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter and fetch sequencer of one PLC core. Fetches
//               opcodes from program ROM, fetches jump target bytes, samples
//               the jump mux condition, and issues a one-cycle valid pulse for
//               every non-jump opcode.
//               Ports: CLK, RST (async, active high), PC_Hold (stall),
//               ROM_InputData (8b, 1-cycle latency), JMPMUX_JMP_EN,
//               ROM_Address (ADDR_W), PC_Opcode (8b), PC_InstrValid,
//               PC_StackErr.
//               Optional feature macro: PC_CALL_STACK_EN (CALL/RET return
//               stack of STACK_DEPTH entries).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_Hold,
    input  logic [7:0]        ROM_InputData,
    input  logic              JMPMUX_JMP_EN,
    output logic [ADDR_W-1:0] ROM_Address,
    output logic [7:0]        PC_Opcode,
    output logic              PC_InstrValid,
    output logic              PC_StackErr
);
    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    pc_state_t          r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [7:0]         r_opcode, w_opcode_nxt;
    logic               r_valid, w_valid_nxt;
    logic [7:0]         r_tgt_lo, w_tgt_lo_nxt;
    logic [ADDR_W-9:0]  r_tgt_hi, w_tgt_hi_nxt;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_target;

    assign w_pc_inc = r_pc + c_pc_one;
    assign w_target = {r_tgt_hi, r_tgt_lo};

`ifdef PC_CALL_STACK_EN
    logic              w_push, w_pop, w_err_set;
    logic [ADDR_W-1:0] w_stk_top;
    logic              w_stk_full, w_stk_empty;
    logic              r_stack_err;

    pc_call_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_call_stack (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_push & ~PC_Hold),
        .i_pop   (w_pop & ~PC_Hold),
        .i_data  (r_pc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stack_err <= 1'b0;
        end else if (!PC_Hold && w_err_set) begin
            r_stack_err <= 1'b1;
        end
    end

    assign PC_StackErr = r_stack_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (STACK_DEPTH > 0);
    assign PC_StackErr  = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_addr_nxt   = r_addr;
        w_opcode_nxt = r_opcode;
        w_valid_nxt  = 1'b0;
        w_tgt_lo_nxt = r_tgt_lo;
        w_tgt_hi_nxt = r_tgt_hi;
`ifdef PC_CALL_STACK_EN
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err_set    = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_addr_nxt  = r_pc;
                w_state_nxt = S_OP;
            end
            S_OP: begin
                w_opcode_nxt = ROM_InputData;
                w_pc_nxt     = w_pc_inc;
                if (!is_jump(ROM_InputData)) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_FETCH;
                end
`ifdef PC_CALL_STACK_EN
                else if (ROM_InputData == OPC_RET) begin
                    if (w_stk_empty) begin
                        w_err_set   = 1'b1;
                        w_pc_nxt    = r_pc;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pop       = 1'b1;
                        w_pc_nxt    = w_stk_top;
                        w_state_nxt = S_FETCH;
                    end
                end
`endif
                else begin
                    // Issue the first operand byte address right away so it
                    // is on the ROM data bus in S_TLO.
                    w_addr_nxt  = w_pc_inc;
                    w_state_nxt = S_TLO;
                end
            end
            S_TLO: begin
                w_tgt_lo_nxt = ROM_InputData;
                w_pc_nxt     = w_pc_inc;
                w_addr_nxt   = w_pc_inc;
                w_state_nxt  = S_THI;
            end
            S_THI: begin
                // Pad bits above the address width are dropped here.
                w_tgt_hi_nxt = ROM_InputData[ADDR_W-9:0];
                w_pc_nxt     = w_pc_inc;
                w_state_nxt  = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
`ifdef PC_CALL_STACK_EN
                if (r_opcode == OPC_CALL) begin
                    // r_pc already points past the operand bytes: that is
                    // the return address.
                    if (w_stk_full) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_target;
                    end
                end else
`endif
                if (JMPMUX_JMP_EN) begin
                    w_pc_nxt = w_target;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_addr   <= '0;
            r_opcode <= 8'h00;
            r_valid  <= 1'b0;
            r_tgt_lo <= '0;
            r_tgt_hi <= '0;
        end else if (!PC_Hold) begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_addr   <= w_addr_nxt;
            r_opcode <= w_opcode_nxt;
            r_valid  <= w_valid_nxt;
            r_tgt_lo <= w_tgt_lo_nxt;
            r_tgt_hi <= w_tgt_hi_nxt;
        end
    end

    // A pending pulse is held in r_valid across a stall and shown once the
    // stall is released, so it is neither lost nor repeated.
    assign PC_InstrValid = r_valid & ~PC_Hold;
    assign ROM_Address   = r_addr;
    assign PC_Opcode     = r_opcode;

endmodule
`default_nettype wire
